concatenador_nonce: RTL

CONCATENADOR_NONCE -- requirements
Module: concatenador_nonce

---
 rtl/concatenador_nonce.sv | 119 +++++++++++
 1 files changed

// File: rtl/concatenador_nonce.sv
// concatenador_nonce: sweeps a nonce range and presents {entrada, nonce} blocks
// to a downstream hash core through a valid/ready handshake.
// Optional build macro CONCATENADOR_NONCE_BSWAP_EN byte-reverses the nonce
// field of bloque_out (byte 0 of the nonce lands in the field's MSBs).
module concatenador_nonce #(
    parameter int ENTRADA_W = 96,
    parameter int NONCE_W   = 32
) (
    input  logic                         clk,
    input  logic                         reset_L,
    input  logic                         start,
    input  logic [ENTRADA_W-1:0]         entrada,
    input  logic [NONCE_W-1:0]           nonce_start,
    input  logic [NONCE_W-1:0]           nonce_end,
    input  logic                         abort,
    input  logic                         ready_in,
    output logic [ENTRADA_W+NONCE_W-1:0] bloque_out,
    output logic                         valid_out,
    output logic                         last_out,
    output logic                         busy,
    output logic                         done,
    output logic [NONCE_W-1:0]           nonce_actual
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [ENTRADA_W-1:0] entrada_reg;
    logic [NONCE_W-1:0]   nonce_end_reg;
    logic [NONCE_W-1:0]   nonce_cnt;
    logic [NONCE_W-1:0]   nonce_field;
    logic                 accept;
    logic                 handshake;
    logic                 at_end;

    // Reverse byte order so the least significant nonce byte sits first.
    function automatic logic [NONCE_W-1:0] byte_swap(input logic [NONCE_W-1:0] x);
        logic [NONCE_W-1:0] r;
        r = '0;
        for (int i = 0; i < NONCE_W / 8; i++) begin
            r[8*i +: 8] = x[NONCE_W-8-8*i +: 8];
        end
        return r;
    endfunction

    // start is only honoured outside RUN, so a running sweep cannot be hijacked.
    assign accept    = start && (state != RUN);
    assign handshake = valid_out && ready_in;
    assign at_end    = (nonce_cnt == nonce_end_reg);

    assign valid_out    = (state == RUN);
    assign busy         = (state == RUN);
    assign done         = (state == DONE);
    assign last_out     = valid_out && at_end;
    assign nonce_actual = nonce_cnt;

`ifdef CONCATENADOR_NONCE_BSWAP_EN
    assign nonce_field = byte_swap(nonce_cnt);
`else
    assign nonce_field = nonce_cnt;
`endif

    // The block is built purely from registered values, so it cannot move
    // during a stall or follow entrada changes while a sweep is running.
    assign bloque_out = {entrada_reg, nonce_field};

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a sweep ends on the handshake of the last block or on abort.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort || (handshake && at_end)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = start ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sweep operands: captured on start, counter advances once per transferred block.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            entrada_reg   <= '0;
            nonce_end_reg <= '0;
            nonce_cnt     <= '0;
        end else if (accept) begin
            entrada_reg   <= entrada;
            nonce_end_reg <= nonce_end;
            nonce_cnt     <= nonce_start;
        end else if (handshake) begin
            nonce_cnt     <= nonce_cnt + 1'b1;
        end
    end

endmodule
